// File: rtl/branch_predict_unit_if.sv
// Purpose: groups the IF lookup and ID resolution signals of branch_predict_unit.
// Latency: wires only; the attached unit answers combinationally.
// Backpressure: none; i_valid is the only qualifier (a stall simply drops i_valid).
// Ports: i_* flow from the pipeline into the unit, o_*/os_* flow back to the pipeline.
interface branch_predict_unit_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  // IF-stage lookup
  logic [DATA_W-1:0] i_if_pc;
  logic              o_pred_taken;
  logic [DATA_W-1:0] o_pred_target;
  // ID-stage resolution
  logic              i_valid;
  logic [5:0]        i_op;
  logic [DATA_W-1:0] i_sign_ext;
  logic [DATA_W-1:0] i_jump_address;
  logic [DATA_W-1:0] i_br_pc;
  logic [DATA_W-1:0] i_pc;
  logic [DATA_W-1:0] i_rs_reg;
  logic [DATA_W-1:0] i_rt_reg;
  logic              i_pred_taken;
  logic [DATA_W-1:0] i_pred_target;
  logic              os_taken;
  logic              os_mispredict;
  logic [DATA_W-1:0] o_redirect_address;
  logic              os_write_pc;
  logic              os_select_addr_reg;
  logic [DATA_W-1:0] o_pc_to_reg;
  // performance counters
  logic [CNT_W-1:0]  o_branch_cnt;
  logic [CNT_W-1:0]  o_mispred_cnt;

  // pipeline side
  modport master (
    output i_if_pc, i_valid, i_op, i_sign_ext, i_jump_address, i_br_pc, i_pc,
           i_rs_reg, i_rt_reg, i_pred_taken, i_pred_target,
    input  o_pred_taken, o_pred_target, os_taken, os_mispredict, o_redirect_address,
           os_write_pc, os_select_addr_reg, o_pc_to_reg, o_branch_cnt, o_mispred_cnt
  );

  // predictor side
  modport slave (
    input  i_if_pc, i_valid, i_op, i_sign_ext, i_jump_address, i_br_pc, i_pc,
           i_rs_reg, i_rt_reg, i_pred_taken, i_pred_target,
    output o_pred_taken, o_pred_target, os_taken, os_mispredict, o_redirect_address,
           os_write_pc, os_select_addr_reg, o_pc_to_reg, o_branch_cnt, o_mispred_cnt
  );
endinterface

// File: rtl/branch_predict_unit.sv
// Purpose: BTB + saturating-counter predictor; resolves BEQ/BNE/J/JAL/JR/JALR in ID.
// Latency: lookup and resolution combinational (0 cycles); training/counters at next edge.
// Backpressure: none; i_valid=0 (stall/bubble) zeroes ID outputs and freezes all state.
// Ports: clk, rst (sync, active-low), io_bpu (slave side of branch_predict_unit_if).
module branch_predict_unit #(
  parameter int DATA_W    = 32,
  parameter int BTB_DEPTH = 16,
  parameter int CTR_W     = 2,
  parameter int CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  branch_predict_unit_if.slave  io_bpu
);
  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = DATA_W - IDX_W;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_JALR    = 6'b001001;

  localparam logic [CTR_W-1:0] CTR_ONE = CTR_W'(1);
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_ONE << (CTR_W - 1);  // 10..0
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_WT - CTR_ONE;        // 01..1
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic              r_valid  [BTB_DEPTH];
  logic [TAG_W-1:0]  r_tag    [BTB_DEPTH];
  logic [DATA_W-1:0] r_target [BTB_DEPTH];
  logic [CTR_W-1:0]  r_ctr    [BTB_DEPTH];
  logic [CNT_W-1:0]  r_branch_cnt;
  logic [CNT_W-1:0]  r_mispred_cnt;

  // IF lookup: reads registered contents only, so a same-cycle update is not visible.
  logic [IDX_W-1:0] w_if_idx;
  logic             w_if_hit;
  logic             w_pred_taken;
  assign w_if_idx     = io_bpu.i_if_pc[IDX_W-1:0];
  assign w_if_hit     = r_valid[w_if_idx] && (r_tag[w_if_idx] == io_bpu.i_if_pc[DATA_W-1:IDX_W]);
  assign w_pred_taken = rst && w_if_hit && r_ctr[w_if_idx][CTR_W-1];

  assign io_bpu.o_pred_taken  = w_pred_taken;
  assign io_bpu.o_pred_target = w_pred_taken ? r_target[w_if_idx] : '0;

  // ID decode
  logic [DATA_W-1:0] w_target;
  logic              w_taken;
  logic              w_is_ctrl;
  logic              w_is_cond;
  logic              w_link;
  logic              w_sel_r31;
  logic [5:0]        w_funct;
  assign w_funct = io_bpu.i_sign_ext[5:0];

  always_comb begin
    w_target  = '0;
    w_taken   = 1'b0;
    w_is_ctrl = 1'b0;
    w_is_cond = 1'b0;
    w_link    = 1'b0;
    w_sel_r31 = 1'b0;
    case (io_bpu.i_op)
      OP_BEQ, OP_BNE: begin
        w_is_ctrl = 1'b1;
        w_is_cond = 1'b1;
        w_target  = io_bpu.i_pc + io_bpu.i_sign_ext;
        w_taken   = (io_bpu.i_rs_reg == io_bpu.i_rt_reg) ^ (io_bpu.i_op == OP_BNE);
      end
      OP_J, OP_JAL: begin
        w_is_ctrl = 1'b1;
        w_taken   = 1'b1;
        w_target  = io_bpu.i_jump_address;
        w_link    = (io_bpu.i_op == OP_JAL);
        w_sel_r31 = (io_bpu.i_op == OP_JAL);
      end
      OP_SPECIAL: begin
        if (w_funct == FN_JR || w_funct == FN_JALR) begin
          w_is_ctrl = 1'b1;
          w_taken   = 1'b1;
          w_target  = io_bpu.i_rs_reg;
          w_link    = (w_funct == FN_JALR);
        end
      end
      default: ;
    endcase
  end

  // Everything on the ID side is qualified by reset and i_valid.
  logic w_res_vld;
  logic w_mispredict;
  assign w_res_vld    = rst && io_bpu.i_valid;
  // Catches both direction errors and right-direction/wrong-target (e.g. JR to a new rs).
  assign w_mispredict = w_res_vld && ((w_taken != io_bpu.i_pred_taken) ||
                                      (w_taken && (io_bpu.i_pred_target != w_target)));

  assign io_bpu.os_taken           = w_res_vld && w_taken;
  assign io_bpu.os_mispredict      = w_mispredict;
  assign io_bpu.o_redirect_address = w_mispredict ? (w_taken ? w_target : io_bpu.i_pc) : '0;
  assign io_bpu.os_write_pc        = w_res_vld && w_link;
  assign io_bpu.os_select_addr_reg = w_res_vld && w_sel_r31;
  assign io_bpu.o_pc_to_reg        = (w_res_vld && w_link) ? io_bpu.i_pc : '0;
  assign io_bpu.o_branch_cnt       = rst ? r_branch_cnt  : '0;
  assign io_bpu.o_mispred_cnt      = rst ? r_mispred_cnt : '0;

  // Training port addressed by the resolving instruction.
  logic [IDX_W-1:0] w_br_idx;
  logic             w_br_hit;
  assign w_br_idx = io_bpu.i_br_pc[IDX_W-1:0];
  assign w_br_hit = r_valid[w_br_idx] && (r_tag[w_br_idx] == io_bpu.i_br_pc[DATA_W-1:IDX_W]);

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < BTB_DEPTH; k++) begin
        r_valid[k]  <= 1'b0;
        r_tag[k]    <= '0;
        r_target[k] <= '0;
        r_ctr[k]    <= CTR_WNT;
      end
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else if (io_bpu.i_valid) begin
      if (w_is_cond) begin
        if (w_br_hit) begin
          if (w_taken) begin
            r_target[w_br_idx] <= w_target;
            if (r_ctr[w_br_idx] != '1) r_ctr[w_br_idx] <= r_ctr[w_br_idx] + CTR_ONE;
          end else if (r_ctr[w_br_idx] != '0) begin
            r_ctr[w_br_idx] <= r_ctr[w_br_idx] - CTR_ONE;
          end
        end else if (w_taken) begin
          r_valid[w_br_idx]  <= 1'b1;
          r_tag[w_br_idx]    <= io_bpu.i_br_pc[DATA_W-1:IDX_W];
          r_target[w_br_idx] <= w_target;
          r_ctr[w_br_idx]    <= CTR_WT;
        end
      end else if (w_is_ctrl) begin
        // Unconditional transfers: always install as strongly taken.
        r_valid[w_br_idx]  <= 1'b1;
        r_tag[w_br_idx]    <= io_bpu.i_br_pc[DATA_W-1:IDX_W];
        r_target[w_br_idx] <= w_target;
        r_ctr[w_br_idx]    <= '1;
      end else if (w_br_hit) begin
        // A non-control instruction aliased onto a live entry: kill it.
        r_valid[w_br_idx] <= 1'b0;
      end
      if (w_is_ctrl && (r_branch_cnt != '1)) r_branch_cnt <= r_branch_cnt + CNT_ONE;
      if (w_mispredict && (r_mispred_cnt != '1)) r_mispred_cnt <= r_mispred_cnt + CNT_ONE;
    end
  end
endmodule

// File: tb/tb_branch_predict_unit.sv
module tb_branch_predict_unit;
  localparam int DW = 32;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  branch_predict_unit_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

  branch_predict_unit #(.DATA_W(DW), .BTB_DEPTH(16), .CTR_W(2), .CNT_W(CW)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bpu (bus)
  );

  task automatic set_id(input logic v, input logic [5:0] op, input logic [DW-1:0] sext,
                        input logic [DW-1:0] jaddr, input logic [DW-1:0] br_pc,
                        input logic [DW-1:0] pc, input logic [DW-1:0] rs, input logic [DW-1:0] rt,
                        input logic ptk, input logic [DW-1:0] ptg);
    bus.i_valid = v; bus.i_op = op; bus.i_sign_ext = sext; bus.i_jump_address = jaddr;
    bus.i_br_pc = br_pc; bus.i_pc = pc; bus.i_rs_reg = rs; bus.i_rt_reg = rt;
    bus.i_pred_taken = ptk; bus.i_pred_target = ptg;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.i_if_pc = 32'h08;
    set_id(1'b1, 6'b000011, 0, 32'h40, 32'h08, 32'h09, 0, 0, 1'b0, 0);
    #1;
    checks++; if (bus.os_taken !== 1'b0) begin errors++; $display("FAIL rst_taken: got %0h want 0", bus.os_taken); end
    checks++; if (bus.os_mispredict !== 1'b0) begin errors++; $display("FAIL rst_mispred: got %0h want 0", bus.os_mispredict); end
    checks++; if (bus.o_pc_to_reg !== 32'h0) begin errors++; $display("FAIL rst_pc_to_reg: got %0h want 0", bus.o_pc_to_reg); end
    tick(); tick();
    rst = 1'b1;
    bus.i_valid = 1'b0;
    #1;
    checks++; if (bus.o_pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred_taken: got %0h want 0", bus.o_pred_taken); end
    checks++; if (bus.o_pred_target !== 32'h0) begin errors++; $display("FAIL reset_pred_target: got %0h want 0", bus.o_pred_target); end
    checks++; if (bus.o_branch_cnt !== 2'd0) begin errors++; $display("FAIL reset_branch_cnt: got %0d want 0", bus.o_branch_cnt); end
    checks++; if (bus.o_mispred_cnt !== 2'd0) begin errors++; $display("FAIL reset_mispred_cnt: got %0d want 0", bus.o_mispred_cnt); end
  endtask

  task automatic test_beq_taken();
    bus.i_if_pc = 32'h08;
    set_id(1'b1, 6'b000100, 32'd4, 0, 32'h08, 32'h09, 32'd5, 32'd5, 1'b0, 0);
    #1;
    checks++; if (bus.os_taken !== 1'b1) begin errors++; $display("FAIL beq_taken: got %0h want 1", bus.os_taken); end
    checks++; if (bus.os_mispredict !== 1'b1) begin errors++; $display("FAIL beq_mispred: got %0h want 1", bus.os_mispredict); end
    checks++; if (bus.o_redirect_address !== 32'h0D) begin errors++; $display("FAIL beq_redirect: got %0h want d", bus.o_redirect_address); end
    checks++; if (bus.o_pred_taken !== 1'b0) begin errors++; $display("FAIL beq_no_bypass: got %0h want 0", bus.o_pred_taken); end
    tick();
    bus.i_valid = 1'b0;
    #1;
    checks++; if (bus.os_taken !== 1'b0) begin errors++; $display("FAIL beq_invalid_gated: got %0h want 0", bus.os_taken); end
    checks++; if (bus.o_pred_taken !== 1'b1) begin errors++; $display("FAIL beq_lookup_taken: got %0h want 1", bus.o_pred_taken); end
    checks++; if (bus.o_pred_target !== 32'h0D) begin errors++; $display("FAIL beq_lookup_target: got %0h want d", bus.o_pred_target); end
    checks++; if (bus.o_mispred_cnt !== 2'd1) begin errors++; $display("FAIL beq_mispred_cnt: got %0d want 1", bus.o_mispred_cnt); end
    checks++; if (bus.o_branch_cnt !== 2'd1) begin errors++; $display("FAIL beq_branch_cnt: got %0d want 1", bus.o_branch_cnt); end
  endtask

  task automatic test_beq_not_taken();
    set_id(1'b1, 6'b000100, 32'd4, 0, 32'h08, 32'h09, 32'd5, 32'd6, 1'b1, 32'h0D);
    #1;
    checks++; if (bus.os_taken !== 1'b0) begin errors++; $display("FAIL beqnt_taken: got %0h want 0", bus.os_taken); end
    checks++; if (bus.os_mispredict !== 1'b1) begin errors++; $display("FAIL beqnt_mispred: got %0h want 1", bus.os_mispredict); end
    checks++; if (bus.o_redirect_address !== 32'h09) begin errors++; $display("FAIL beqnt_redirect: got %0h want 9", bus.o_redirect_address); end
    tick();
    bus.i_valid = 1'b0;
    #1;
    checks++; if (bus.o_pred_taken !== 1'b0) begin errors++; $display("FAIL beqnt_lookup_taken: got %0h want 0", bus.o_pred_taken); end
    checks++; if (bus.o_pred_target !== 32'h0) begin errors++; $display("FAIL beqnt_lookup_target: got %0h want 0", bus.o_pred_target); end
    checks++; if (bus.o_branch_cnt !== 2'd2) begin errors++; $display("FAIL beqnt_branch_cnt: got %0d want 2", bus.o_branch_cnt); end
    checks++; if (bus.o_mispred_cnt !== 2'd2) begin errors++; $display("FAIL beqnt_mispred_cnt: got %0d want 2", bus.o_mispred_cnt); end
  endtask

  // Entry at 0x08 holds ctr=01, target 0x0D. Walk it 01->10->11->11->10.
  task automatic test_ctr_train();
    logic [DW-1:0] ptg [4]  = '{32'h0, 32'h0F, 32'h0F, 32'h0F};
    logic          ptk [4]  = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [DW-1:0] rt  [4]  = '{32'd5, 32'd5, 32'd5, 32'd7};
    logic          emis [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [DW-1:0] ered [4] = '{32'h0F, 32'h0, 32'h0, 32'h09};
    for (int i = 0; i < 4; i++) begin
      set_id(1'b1, 6'b000100, 32'd6, 0, 32'h08, 32'h09, 32'd5, rt[i], ptk[i], ptg[i]);
      #1;
      checks++; if (bus.os_mispredict !== emis[i]) begin errors++; $display("FAIL ctr_mispred[%0d]: got %0h want %0h", i, bus.os_mispredict, emis[i]); end
      checks++; if (bus.o_redirect_address !== ered[i]) begin errors++; $display("FAIL ctr_redirect[%0d]: got %0h want %0h", i, bus.o_redirect_address, ered[i]); end
      tick();
    end
    bus.i_valid = 1'b0;
    bus.i_if_pc = 32'h08;
    #1;
    checks++; if (bus.o_pred_taken !== 1'b1) begin errors++; $display("FAIL ctr_sat_taken: got %0h want 1", bus.o_pred_taken); end
    checks++; if (bus.o_pred_target !== 32'h0F) begin errors++; $display("FAIL ctr_target: got %0h want f", bus.o_pred_target); end
  endtask

  task automatic test_bne();
    // taken, negative offset wraps: 0x04 + 0xFFFFFFFE = 0x02
    set_id(1'b1, 6'b000101, 32'hFFFF_FFFE, 0, 32'h03, 32'h04, 32'd1, 32'd2, 1'b0, 0);
    #1;
    checks++; if (bus.o_redirect_address !== 32'h02) begin errors++; $display("FAIL bne_redirect: got %0h want 2", bus.o_redirect_address); end
    tick();
    // not taken and a miss: no allocation, no mispredict
    set_id(1'b1, 6'b000101, 32'd8, 0, 32'h05, 32'h06, 32'd3, 32'd3, 1'b0, 0);
    #1;
    checks++; if (bus.os_mispredict !== 1'b0) begin errors++; $display("FAIL bne_nt_mispred: got %0h want 0", bus.os_mispredict); end
    tick();
    bus.i_valid = 1'b0;
    bus.i_if_pc = 32'h03;
    #1;
    checks++; if (bus.o_pred_target !== 32'h02) begin errors++; $display("FAIL bne_lookup_target: got %0h want 2", bus.o_pred_target); end
    bus.i_if_pc = 32'h05;
    #1;
    checks++; if (bus.o_pred_taken !== 1'b0) begin errors++; $display("FAIL bne_nt_no_alloc: got %0h want 0", bus.o_pred_taken); end
  endtask

  task automatic test_jal();
    set_id(1'b1, 6'b000011, 0, 32'h40, 32'h20, 32'h21, 0, 0, 1'b1, 32'h40);
    #1;
    checks++; if (bus.os_taken !== 1'b1) begin errors++; $display("FAIL jal_taken: got %0h want 1", bus.os_taken); end
    checks++; if (bus.os_mispredict !== 1'b0) begin errors++; $display("FAIL jal_mispred: got %0h want 0", bus.os_mispredict); end
    checks++; if (bus.o_redirect_address !== 32'h0) begin errors++; $display("FAIL jal_redirect: got %0h want 0", bus.o_redirect_address); end
    checks++; if (bus.os_write_pc !== 1'b1) begin errors++; $display("FAIL jal_write_pc: got %0h want 1", bus.os_write_pc); end
    checks++; if (bus.os_select_addr_reg !== 1'b1) begin errors++; $display("FAIL jal_sel_r31: got %0h want 1", bus.os_select_addr_reg); end
    checks++; if (bus.o_pc_to_reg !== 32'h21) begin errors++; $display("FAIL jal_pc_to_reg: got %0h want 21", bus.o_pc_to_reg); end
    tick();
  endtask

  task automatic test_jalr();
    set_id(1'b1, 6'b000000, 32'h09, 0, 32'h20, 32'h21, 32'h80, 0, 1'b1, 32'h40);
    #1;
    checks++; if (bus.os_mispredict !== 1'b1) begin errors++; $display("FAIL jalr_mispred: got %0h want 1", bus.os_mispredict); end
    checks++; if (bus.o_redirect_address !== 32'h80) begin errors++; $display("FAIL jalr_redirect: got %0h want 80", bus.o_redirect_address); end
    checks++; if (bus.os_select_addr_reg !== 1'b0) begin errors++; $display("FAIL jalr_sel_r31: got %0h want 0", bus.os_select_addr_reg); end
    checks++; if (bus.os_write_pc !== 1'b1) begin errors++; $display("FAIL jalr_write_pc: got %0h want 1", bus.os_write_pc); end
    tick();
    bus.i_valid = 1'b0;
    bus.i_if_pc = 32'h20;
    #1;
    checks++; if (bus.o_pred_target !== 32'h80) begin errors++; $display("FAIL jalr_btb_target: got %0h want 80", bus.o_pred_target); end
    // JR: no link, target from rs
    set_id(1'b1, 6'b000000, 32'h08, 0, 32'h20, 32'h21, 32'h100, 0, 1'b1, 32'h80);
    #1;
    checks++; if (bus.o_redirect_address !== 32'h100) begin errors++; $display("FAIL jr_redirect: got %0h want 100", bus.o_redirect_address); end
    checks++; if (bus.os_write_pc !== 1'b0) begin errors++; $display("FAIL jr_write_pc: got %0h want 0", bus.os_write_pc); end
    tick();
  endtask

  task automatic test_alias();
    set_id(1'b1, 6'b000010, 0, 32'h50, 32'h18, 32'h19, 0, 0, 1'b0, 0);
    tick();
    bus.i_valid = 1'b0;
    bus.i_if_pc = 32'h18;
    #1;
    checks++; if (bus.o_pred_target !== 32'h50) begin errors++; $display("FAIL j_alloc_target: got %0h want 50", bus.o_pred_target); end
    bus.i_if_pc = 32'h08;
    #1;
    checks++; if (bus.o_pred_taken !== 1'b0) begin errors++; $display("FAIL tag_mismatch: got %0h want 0", bus.o_pred_taken); end
    // load (op 100011) aliased as predicted-taken
    set_id(1'b1, 6'b100011, 0, 0, 32'h18, 32'h19, 0, 0, 1'b1, 32'h50);
    #1;
    checks++; if (bus.os_taken !== 1'b0) begin errors++; $display("FAIL alias_taken: got %0h want 0", bus.os_taken); end
    checks++; if (bus.os_mispredict !== 1'b1) begin errors++; $display("FAIL alias_mispred: got %0h want 1", bus.os_mispredict); end
    checks++; if (bus.o_redirect_address !== 32'h19) begin errors++; $display("FAIL alias_redirect: got %0h want 19", bus.o_redirect_address); end
    tick();
    bus.i_valid = 1'b0;
    bus.i_if_pc = 32'h18;
    #1;
    checks++; if (bus.o_pred_taken !== 1'b0) begin errors++; $display("FAIL alias_invalidated: got %0h want 0", bus.o_pred_taken); end
  endtask

  task automatic test_valid_gate();
    set_id(1'b0, 6'b000011, 0, 32'h60, 32'h30, 32'h31, 0, 0, 1'b0, 0);
    bus.i_if_pc = 32'h30;
    #1;
    checks++; if (bus.os_mispredict !== 1'b0) begin errors++; $display("FAIL gate_mispred: got %0h want 0", bus.os_mispredict); end
    checks++; if (bus.os_write_pc !== 1'b0) begin errors++; $display("FAIL gate_write_pc: got %0h want 0", bus.os_write_pc); end
    tick();
    checks++; if (bus.o_pred_taken !== 1'b0) begin errors++; $display("FAIL gate_no_train: got %0h want 0", bus.o_pred_taken); end
  endtask

  task automatic test_reset_mid();
    set_id(1'b1, 6'b000010, 0, 32'h60, 32'h30, 32'h31, 0, 0, 1'b0, 0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_if_pc = 32'h30;
    #1;
    checks++; if (bus.o_pred_taken !== 1'b0) begin errors++; $display("FAIL midrst_discard: got %0h want 0", bus.o_pred_taken); end
    bus.i_if_pc = 32'h20;
    #1;
    checks++; if (bus.o_pred_taken !== 1'b0) begin errors++; $display("FAIL midrst_cleared: got %0h want 0", bus.o_pred_taken); end
    checks++; if (bus.o_branch_cnt !== 2'd0) begin errors++; $display("FAIL midrst_branch_cnt: got %0d want 0", bus.o_branch_cnt); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 4; i++) begin
      set_id(1'b1, 6'b000010, 0, 32'h44, 32'h01, 32'h02, 0, 0, 1'b1, 32'h44);
      tick();
      if (i == 1) begin
        checks++; if (bus.o_branch_cnt !== 2'd2) begin errors++; $display("FAIL sat_branch_mid: got %0d want 2", bus.o_branch_cnt); end
      end
    end
    checks++; if (bus.o_branch_cnt !== 2'd3) begin errors++; $display("FAIL sat_branch_cnt: got %0d want 3", bus.o_branch_cnt); end
    checks++; if (bus.o_mispred_cnt !== 2'd0) begin errors++; $display("FAIL sat_no_mispred: got %0d want 0", bus.o_mispred_cnt); end
    for (int i = 0; i < 4; i++) begin
      set_id(1'b1, 6'b000100, 32'd3, 0, 32'h02, 32'h03, 32'd1, 32'd2, 1'b1, 32'h06);
      tick();
    end
    checks++; if (bus.o_mispred_cnt !== 2'd3) begin errors++; $display("FAIL sat_mispred_cnt: got %0d want 3", bus.o_mispred_cnt); end
    checks++; if (bus.o_branch_cnt !== 2'd3) begin errors++; $display("FAIL sat_branch_hold: got %0d want 3", bus.o_branch_cnt); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_beq_taken();
    test_beq_not_taken();
    test_ctr_train();
    test_bne();
    test_jal();
    test_jalr();
    test_alias();
    test_valid_gate();
    test_reset_mid();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
